// File: rtl/data_mem_resp.sv
// data_mem_resp
//   Memory end of the load/store interface, modelled as a slow, handshaked
//   slave. It accepts one request at a time and holds it for WAIT_CYCLES
//   extra cycles. It then performs a little-endian byte, halfword or word
//   access and answers with a single ack pulse carrying read data or an
//   error flag.
//
//   State table:
//     IDLE | waiting for req; request fields are latched on acceptance
//     WAIT | counting down the wait counter; access happens on the exit edge
//     RESP | ack (and err/rdata) presented for exactly one cycle
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   req          request valid, sampled only in IDLE
//   we           1 = store, 0 = load
//   addr[31:0]   byte address (word index = addr[31:2])
//   wdata[31:0]  store data, right-aligned
//   size[1:0]    00 byte, 01 halfword, 10 word, 11 illegal
//   unsigned_ld  1 = zero-extend narrow loads, 0 = sign-extend
//   rdata[31:0]  load result, valid while ack = 1
//   ack          one-cycle response pulse
//   err          error flag, qualified by ack
//   busy         high from acceptance until the cycle after ack
module data_mem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        latch_en;
  logic        access;

  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [1:0]  l_size;
  logic        l_uns;

  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          misalign;
  logic          acc_err;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic [31:0]   rd_shift;
  logic [31:0]   load_val;
  logic [3:0]    be;
  logic [31:0]   wd_lane;
  logic          mem_we;

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_en = 1'b0;
    access   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d  = ST_WAIT;
          cnt_d    = 4'(WAIT_CYCLES);
          latch_en = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          access  = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Access decode, all from latched fields so the requester may move on
  // after acceptance.
  always_comb begin
    misalign = ((l_size == 2'b01) && l_addr[0]) ||
               ((l_size == 2'b10) && (l_addr[1:0] != 2'b00));
    acc_err  = misalign || (l_size == 2'b11) ||
               ({2'b00, l_addr[31:2]} >= 32'(DEPTH_WORDS));
    idx      = l_addr[AW+1:2];
  end

  assign rd_word = mem[idx];
  // A halfword is aligned, so a shift by addr[1:0] bytes right-aligns
  // either a byte or a halfword lane.
  assign rd_shift = rd_word >> {l_addr[1:0], 3'b000};

  always_comb begin
    load_val = 32'd0;
    case (l_size)
      2'b00:   load_val = {{24{~l_uns & rd_shift[7]}},  rd_shift[7:0]};
      2'b01:   load_val = {{16{~l_uns & rd_shift[15]}}, rd_shift[15:0]};
      2'b10:   load_val = rd_word;
      default: load_val = 32'd0;
    endcase
  end

  // Store lane enables; data is replicated so every enabled lane sees it.
  always_comb begin
    be      = 4'b0000;
    wd_lane = l_wdata;
    case (l_size)
      2'b00: begin
        be      = 4'b0001 << l_addr[1:0];
        wd_lane = {4{l_wdata[7:0]}};
      end
      2'b01: begin
        be      = l_addr[1] ? 4'b1100 : 4'b0011;
        wd_lane = {2{l_wdata[15:0]}};
      end
      2'b10: begin
        be      = 4'b1111;
        wd_lane = l_wdata;
      end
      default: begin
        be      = 4'b0000;
        wd_lane = l_wdata;
      end
    endcase
  end

  assign mem_we = access && l_we && !acc_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      l_we    <= 1'b0;
      l_addr  <= 32'd0;
      l_wdata <= 32'd0;
      l_size  <= 2'b00;
      l_uns   <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_en) begin
        l_we    <= we;
        l_addr  <= addr;
        l_wdata <= wdata;
        l_size  <= size;
        l_uns   <= unsigned_ld;
      end
      // rdata/err only carry a value during RESP; cleared on the way out.
      if (access) begin
        rdata_q <= (acc_err || l_we) ? 32'd0 : load_val;
        err_q   <= acc_err;
      end else begin
        rdata_q <= 32'd0;
        err_q   <= 1'b0;
      end
    end
  end

  // Storage is not reset; a reset in WAIT forces IDLE so no write follows.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wd_lane[8*b +: 8];
      end
    end
  end

  assign rdata = rdata_q;
  assign err   = err_q;
  assign ack   = (state_q == ST_RESP);
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        uns;
  logic        sel0;

  logic        req_a, req_b;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;
  logic [31:0] rdata_m;
  logic        ack_m, err_m, busy_m;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign req_a   = req & ~sel0;
  assign req_b   = req & sel0;
  assign rdata_m = sel0 ? rdata_b : rdata_a;
  assign ack_m   = sel0 ? ack_b   : ack_a;
  assign err_m   = sel0 ? err_b   : err_a;
  assign busy_m  = sel0 ? busy_b  : busy_a;

  data_mem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .unsigned_ld(uns), .rdata(rdata_a), .ack(ack_a),
    .err(err_a), .busy(busy_a)
  );

  data_mem_resp #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_b (
    .clk(clk), .rst(rst), .req(req_b), .we(we), .addr(addr), .wdata(wdata),
    .size(size), .unsigned_ld(uns), .rdata(rdata_b), .ack(ack_b),
    .err(err_b), .busy(busy_b)
  );

  typedef struct {
    logic        sel0;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic s, logic w, logic [31:0] a, logic [31:0] d,
                              logic [1:0] sz, logic u, logic [31:0] er, logic ee);
    vec_t v;
    v.sel0 = s; v.we = w; v.addr = a; v.wdata = d; v.size = sz; v.uns = u;
    v.exp_rd = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete handshake; request fields are scrambled right after
  // acceptance so only latched values can produce the right answer.
  task automatic apply(input vec_t v, input string nm);
    int lat, bcnt, w;
    logic [31:0] rd;
    logic e, b_after;
    w = v.sel0 ? 0 : 2;
    @(negedge clk);
    sel0 = v.sel0; we = v.we; addr = v.addr; wdata = v.wdata;
    size = v.size; uns = v.uns; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; we = ~v.we; addr = 32'hFFFF_FFFF; wdata = ~v.wdata; size = 2'b11; uns = ~v.uns;
    bcnt = busy_m ? 1 : 0;
    lat = -1; rd = 32'd0; e = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (busy_m) bcnt++;
      if (ack_m) begin
        lat = n; rd = rdata_m; e = err_m;
        break;
      end
    end
    @(posedge clk); #1;
    b_after = busy_m;
    chk({nm, "_latency"}, 32'(lat), 32'(w + 1));
    chk({nm, "_rdata"}, rd, v.exp_rd);
    chk({nm, "_err"}, {31'd0, e}, {31'd0, v.exp_err});
    chk({nm, "_busy_cycles"}, 32'(bcnt), 32'(w + 2));
    chk({nm, "_busy_after"}, {31'd0, b_after}, 32'd0);
  endtask

  // req held high: one ack per WAIT_CYCLES+3 cycles.
  task automatic held(input logic s);
    int w, p;
    logic expv;
    w = s ? 0 : 2;
    p = w + 3;
    @(negedge clk);
    sel0 = s; we = 1'b1; addr = 32'h18; wdata = 32'h1122_3344; size = 2'b10; uns = 1'b0;
    req = 1'b1;
    for (int e = 0; e < 4 * p; e++) begin
      @(posedge clk); #1;
      expv = (e >= w + 1) && (((e - (w + 1)) % p) == 0);
      chk($sformatf("held%0d_ack_e%0d", s, e), {31'd0, ack_m}, {31'd0, expv});
    end
    req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_seen;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    size = 2'b00; uns = 1'b0; sel0 = 1'b0;

    #3;
    chk("reset_ack", {31'd0, ack_a}, 32'd0);
    chk("reset_busy", {31'd0, busy_a}, 32'd0);
    chk("reset_err", {31'd0, err_a}, 32'd0);
    chk("reset_rdata", rdata_a, 32'd0);
    @(negedge clk); rst = 1'b0;

    vt.push_back(mk(0, 1, 32'h10,  32'hDEAD_BEEF, 2'b10, 0, 32'h0,         0));
    vt.push_back(mk(0, 0, 32'h10,  32'h0,        2'b10, 0, 32'hDEAD_BEEF, 0));
    vt.push_back(mk(0, 0, 32'h13,  32'h0,        2'b00, 0, 32'hFFFF_FFDE, 0));
    vt.push_back(mk(0, 0, 32'h13,  32'h0,        2'b00, 1, 32'h0000_00DE, 0));
    vt.push_back(mk(0, 0, 32'h12,  32'h0,        2'b01, 0, 32'hFFFF_DEAD, 0));
    vt.push_back(mk(0, 0, 32'h10,  32'h0,        2'b01, 1, 32'h0000_BEEF, 0));
    vt.push_back(mk(0, 1, 32'h11,  32'hAAAA_AA55, 2'b00, 0, 32'h0,         0));
    vt.push_back(mk(0, 0, 32'h10,  32'h0,        2'b10, 0, 32'hDEAD_55EF, 0));
    vt.push_back(mk(0, 0, 32'h12,  32'h0,        2'b10, 0, 32'h0,         1));
    vt.push_back(mk(0, 1, 32'h11,  32'h0000_1234, 2'b01, 0, 32'h0,         1));
    vt.push_back(mk(0, 0, 32'h10,  32'h0,        2'b10, 0, 32'hDEAD_55EF, 0));
    vt.push_back(mk(0, 0, 32'h10,  32'h0,        2'b11, 0, 32'h0,         1));
    vt.push_back(mk(0, 0, 32'h1000, 32'h0,       2'b10, 0, 32'h0,         1));
    vt.push_back(mk(0, 1, 32'hFFC, 32'h8001_8002, 2'b10, 0, 32'h0,         0));
    vt.push_back(mk(0, 0, 32'hFFE, 32'h0,        2'b01, 0, 32'hFFFF_8001, 0));
    vt.push_back(mk(0, 0, 32'hFFC, 32'h0,        2'b00, 1, 32'h0000_0002, 0));
    vt.push_back(mk(0, 0, 32'hFFD, 32'h0,        2'b00, 0, 32'hFFFF_FF80, 0));
    vt.push_back(mk(0, 0, 32'hFFC, 32'h0,        2'b10, 1, 32'h8001_8002, 0));
    vt.push_back(mk(0, 1, 32'h14,  32'h0,        2'b10, 0, 32'h0,         0));
    vt.push_back(mk(0, 1, 32'h16,  32'h1234_CAFE, 2'b01, 0, 32'h0,         0));
    vt.push_back(mk(0, 0, 32'h14,  32'h0,        2'b10, 0, 32'hCAFE_0000, 0));
    vt.push_back(mk(0, 1, 32'h20,  32'hA5A5_A5A5, 2'b10, 0, 32'h0,         0));
    vt.push_back(mk(1, 1, 32'h8,   32'h0102_0304, 2'b10, 0, 32'h0,         0));
    vt.push_back(mk(1, 0, 32'h8,   32'h0,        2'b10, 0, 32'h0102_0304, 0));
    vt.push_back(mk(1, 0, 32'hA,   32'h0,        2'b00, 0, 32'h0000_0002, 0));
    vt.push_back(mk(1, 0, 32'h40,  32'h0,        2'b10, 0, 32'h0,         1));

    foreach (vt[i]) apply(vt[i], $sformatf("vec%0d", i));

    // Fields of the second request are taken at its own acceptance in IDLE.
    @(negedge clk);
    sel0 = 1'b0; we = 1'b0; addr = 32'h10; size = 2'b10; uns = 1'b0; req = 1'b1;
    @(posedge clk);                        // A
    @(negedge clk); addr = 32'h12;         // misaligned word while busy
    @(posedge clk); @(posedge clk); @(posedge clk); #1;  // A+3
    chk("seq1_ack", {31'd0, ack_a}, 32'd1);
    chk("seq1_rdata", rdata_a, 32'hDEAD_55EF);
    chk("seq1_err", {31'd0, err_a}, 32'd0);
    @(posedge clk);                        // A+4 back to IDLE
    @(negedge clk); addr = 32'h13; size = 2'b00; uns = 1'b1;
    @(posedge clk); #1; req = 1'b0;        // A+5 accept
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("seq2_ack", {31'd0, ack_a}, 32'd1);
    chk("seq2_rdata", rdata_a, 32'h0000_00DE);
    chk("seq2_err", {31'd0, err_a}, 32'd0);
    @(posedge clk);

    held(1'b0);
    apply(mk(0, 0, 32'h18, 32'h0, 2'b10, 0, 32'h1122_3344, 0), "held0_data");
    held(1'b1);
    apply(mk(1, 0, 32'h18, 32'h0, 2'b10, 0, 32'h1122_3344, 0), "held1_data");

    // Reset one cycle into WAIT of a store: no ack, storage untouched.
    @(negedge clk);
    sel0 = 1'b0; we = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; size = 2'b10; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;        // A
    @(posedge clk); #2;                    // A+1, in WAIT
    chk("rstmid_busy_before", {31'd0, busy_a}, 32'd1);
    rst = 1'b1; #1;
    chk("rstmid_busy", {31'd0, busy_a}, 32'd0);
    chk("rstmid_ack", {31'd0, ack_a}, 32'd0);
    chk("rstmid_rdata", rdata_a, 32'd0);
    @(negedge clk); rst = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ack_a) ack_seen++;
    end
    chk("rstmid_no_ack", 32'(ack_seen), 32'd0);
    apply(mk(0, 0, 32'h20, 32'h0, 2'b10, 0, 32'hA5A5_A5A5, 0), "rstmid_data");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder: the memory end of the datapath's load/store interface, as a multi-cycle, handshaked slave.
- Accepts one load or store request at a time and waits a fixed number of cycles.
- Performs a little-endian byte, halfword or word access, then returns one ack pulse with read data or an error flag.
- Replaces the zero-latency data memory when slow-memory timing is modelled.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words of storage; word index = addr[31:2].
- WAIT_CYCLES, 2, extra wait cycles between acceptance and response (legal range 0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  1  request valid; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- addr  input  32  byte address.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
- unsigned_ld  input  1  1 = zero-extend narrow loads, 0 = sign-extend.
- rdata  output  32  load result; valid only while ack = 1.
- ack  output  1  one-cycle response pulse.
- err  output  1  qualified by ack; misaligned, illegal size or out-of-range.
- busy  output  1  high from acceptance until the cycle after ack.

Behaviour:
- Reset (asynchronous, active-high): state IDLE, wait counter 0, rdata 0, ack 0, err 0, busy 0.
- Storage array is not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with req = 1, latch we, addr, wdata, size and unsigned_ld, load counter with WAIT_CYCLES, go to WAIT.
  - busy = 1 from that edge.
- WAIT:
  - Counter != 0: decrement each edge.
  - Counter == 0: next edge goes to RESP and performs the access at that same edge.
- RESP:
  - ack = 1, busy = 1 for exactly one cycle; next edge returns to IDLE with ack = 0, busy = 0, rdata = 0.
- Latency:
  - ack is high in the cycle after edge A+WAIT_CYCLES+1, where A is the acceptance edge.
  - The next request can be accepted no earlier than edge A+WAIT_CYCLES+3.
- req is ignored while busy.
- Latched fields are used, so inputs may change after acceptance.
- Alignment checks:
  - Halfword needs addr[0] = 0.
  - Word needs addr[1:0] = 00.
  - Byte is always aligned.
- Error conditions:
  - Any of: misaligned access, size = 11, or addr[31:2] >= DEPTH_WORDS.
  - Result: err = 1 with ack, rdata = 0, no storage write.
- Store:
  - Byte writes lane addr[1:0] with wdata[7:0].
  - Halfword writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - Word writes all four lanes.
  - Other lanes are untouched.
  - rdata = 0 on store ack.
- Load:
  - Selects the lane(s) little-endian and right-aligns them.
  - Bits above the selected width are sign bit (unsigned_ld = 0) or 0 (unsigned_ld = 1).
  - Word loads ignore unsigned_ld.
- Reset during WAIT or RESP aborts the access; a pending store does not modify storage.
- WAIT_CYCLES = 0: WAIT lasts one cycle, and ack rises at edge A+1.

Test Plan:
- Word store then load, WAIT_CYCLES = 2:
  - Store addr 0x10, wdata 0xDEADBEEF → ack at edge A+3, err = 0.
  - Load word from 0x10 → rdata 0xDEADBEEF; busy high for 4 cycles per access.
- Byte/half lanes after that word:
  - Load byte 0x13 signed → 0xFFFFFFDE.
  - Load byte 0x13 unsigned → 0x000000DE.
  - Load half 0x12 signed → 0xFFFFDEAD.
  - Store byte 0x11 wdata 0x55, then load word 0x10 → 0xDEAD55EF.
- Errors:
  - Load word 0x12 → ack with err = 1, rdata 0.
  - Store half 0x11 → err = 1, and word 0x10 is unchanged.
  - size 11 → err = 1.
  - Word address DEPTH_WORDS*4 → err = 1.
- Request while busy:
  - Hold req high continuously → exactly one ack per WAIT_CYCLES+3 cycles.
  - Second request's fields are sampled in IDLE, not earlier.
- Reset mid-operation:
  - Assert rst one cycle into WAIT of a store of 0x12345678 to 0x20.
  - Outputs go to 0 immediately (asynchronous reset), no ack follows.
  - Later load of 0x20 returns its prior value.
- WAIT_CYCLES = 0 build: store then load → ack one edge after acceptance; back-to-back period 3 cycles.
